// File: rtl/sum_tree_acc_pkg.sv
// Sizing helpers shared by the sum_tree_acc adder-tree reducer and its tree levels.
`ifndef SUM_TREE_ACC_PKG_SV
`define SUM_TREE_ACC_PKG_SV

`define SUM_TREE_ACC_WIDTH_CHECK(acc_w, tree_w) \
  if ((acc_w) < (tree_w)) begin : g_width_check \
    $error("sum_tree_acc: ACC_W is narrower than the adder-tree output"); \
  end

package sum_tree_acc_pkg;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int tree_levels(input int n);
    return clog2(n);
  endfunction

  function automatic int level_width(input int in_w, input int k);
    return in_w + k;
  endfunction

  // Operand count entering level k: ceil(n / 2^k).
  function automatic int level_count(input int n, input int k);
    return (n + (1 << k) - 1) >> k;
  endfunction

endpackage

`endif

// File: rtl/sum_tree_acc_level.sv
// One combinational adder-tree level: M operands of W bits in, ceil(M/2) sums of W+1 bits out.
module sum_tree_acc_level #(
  parameter int M = 2,
  parameter int W = 8
) (
  input  logic [M*W-1:0]             in_data,
  output logic [((M+1)/2)*(W+1)-1:0] out_data
);

  localparam int M_OUT = (M + 1) / 2;

  for (genvar i = 0; i < M_OUT; i++) begin : g_pair
    if (2 * i + 1 < M) begin : g_add
      assign out_data[i*(W+1) +: W+1] = {1'b0, in_data[2*i*W +: W]} + {1'b0, in_data[(2*i+1)*W +: W]};
    end else begin : g_pass
      // The unpaired odd operand rides up one level zero-extended.
      assign out_data[i*(W+1) +: W+1] = {1'b0, in_data[2*i*W +: W]};
    end
  end

endmodule

// File: rtl/sum_tree_acc.sv
// Pipelined adder-tree reducer with first/last framed accumulation, feeding the normaliser.
module sum_tree_acc
  import sum_tree_acc_pkg::*;
#(
  parameter int N_IN      = 121,
  parameter int IN_W      = 14,
  parameter int REG_EVERY = 2,
  parameter int ACC_W     = 24,
  parameter bit ACC_EN    = 1'b1,
  parameter bit SAT       = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic                 in_first,
  input  logic                 in_last,
  input  logic [N_IN*IN_W-1:0] in_data,
  output logic                 sum_valid,
  output logic [ACC_W-1:0]     sum_out,
  output logic                 ovf
);

  localparam int L      = tree_levels(N_IN);
  localparam int TREE_W = level_width(IN_W, L);

  `SUM_TREE_ACC_WIDTH_CHECK(ACC_W, TREE_W)

  logic [TREE_W-1:0] tree_sum;
  logic              tree_valid;
  logic              tree_first;
  logic              tree_last;

  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int M_IN  = level_count(N_IN, k);
    localparam int M_OUT = level_count(N_IN, k + 1);
    localparam int W_IN  = level_width(IN_W, k);

    logic [M_IN*W_IN-1:0]      d_in;
    logic [M_OUT*(W_IN+1)-1:0] d_sum;
    logic [M_OUT*(W_IN+1)-1:0] d_out;
    logic                      v_in, f_in, l_in;
    logic                      v_out, f_out, l_out;

    if (k == 0) begin : g_src
      // With accumulation off every beat is a complete frame.
      assign d_in = in_data;
      assign v_in = in_valid;
      assign f_in = in_first | ~ACC_EN;
      assign l_in = in_last | ~ACC_EN;
    end else begin : g_chain
      assign d_in = g_lvl[k-1].d_out;
      assign v_in = g_lvl[k-1].v_out;
      assign f_in = g_lvl[k-1].f_out;
      assign l_in = g_lvl[k-1].l_out;
    end

    sum_tree_acc_level #(
      .M(M_IN),
      .W(W_IN)
    ) u_level (
      .in_data (d_in),
      .out_data(d_sum)
    );

    if (((k + 1) % REG_EVERY == 0) || (k + 1 == L)) begin : g_reg
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          d_out <= '0;
          v_out <= 1'b0;
          f_out <= 1'b0;
          l_out <= 1'b0;
        end else begin
          d_out <= d_sum;
          v_out <= v_in & ~clear;
          f_out <= f_in;
          l_out <= l_in;
        end
      end
    end else begin : g_wire
      assign d_out = d_sum;
      assign v_out = v_in;
      assign f_out = f_in;
      assign l_out = l_in;
    end
  end

  assign tree_sum   = g_lvl[L-1].d_out;
  assign tree_valid = g_lvl[L-1].v_out;
  assign tree_first = g_lvl[L-1].f_out;
  assign tree_last  = g_lvl[L-1].l_out;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W:0]   acc_sum;
  logic             acc_over;

  // One extra carry bit detects overflow; a frame start discards the running sum.
  always_comb begin
    acc_base = tree_first ? '0 : acc;
    acc_sum  = {1'b0, acc_base} + {{(ACC_W + 1 - TREE_W){1'b0}}, tree_sum};
    acc_over = acc_sum[ACC_W];
    acc_next = (acc_over && SAT) ? '1 : acc_sum[ACC_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
      ovf       <= 1'b0;
    end else if (clear) begin
      acc       <= '0;
      sum_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      if (tree_valid) begin
        if (acc_over) begin
          ovf <= 1'b1;
        end
        if (tree_last) begin
          sum_out   <= acc_next;
          sum_valid <= 1'b1;
          acc       <= '0;
        end else begin
          acc <= acc_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_sum_tree_acc.sv
// Scoreboard bench for sum_tree_acc: four parameterisations share one control stream.
module tb_sum_tree_acc;

  localparam int NB = 121;
  localparam int WB = 14;
  localparam int NS = 5;
  localparam int WS = 4;
  localparam int NI = 4;

  // Per-instance view: 0 defaults, 1 ACC_W=21 saturating, 2 ACC_W=21 wrapping, 3 small tree.
  localparam int NOPS [NI] = '{121, 121, 121, 5};
  localparam int OPW  [NI] = '{14, 14, 14, 4};
  localparam int AW   [NI] = '{24, 21, 21, 24};
  localparam bit SATV [NI] = '{1'b1, 1'b1, 1'b0, 1'b1};
  localparam int DLY  [NI] = '{4, 4, 4, 3};

  logic              clk = 1'b0;
  logic              reset;
  logic              clear;
  logic              in_valid;
  logic              in_first;
  logic              in_last;
  logic [NB*WB-1:0]  data_big;
  logic [NS*WS-1:0]  data_small;
  logic              sv0, sv1, sv2, sv3;
  logic              ov0, ov1, ov2, ov3;
  logic [23:0]       so0, so3;
  logic [20:0]       so1, so2;

  logic [23:0]       obs_sum [NI];
  logic              obs_v   [NI];
  logic              obs_ovf [NI];

  typedef struct {
    int     inst;
    longint sum;
    bit     ovf;
    int     due;
  } exp_t;

  exp_t        sbq[$];
  int unsigned ops [NB];
  longint      m_acc [NI];
  bit          m_ovf [NI];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sum_tree_acc #(.ACC_W(24), .SAT(1'b1)) dut_def (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .in_data(data_big), .sum_valid(sv0), .sum_out(so0), .ovf(ov0));

  sum_tree_acc #(.ACC_W(21), .SAT(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .in_data(data_big), .sum_valid(sv1), .sum_out(so1), .ovf(ov1));

  sum_tree_acc #(.ACC_W(21), .SAT(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .in_data(data_big), .sum_valid(sv2), .sum_out(so2), .ovf(ov2));

  sum_tree_acc #(.N_IN(NS), .IN_W(WS), .REG_EVERY(1)) dut_small (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .in_data(data_small), .sum_valid(sv3), .sum_out(so3), .ovf(ov3));

  assign obs_sum[0] = so0;
  assign obs_sum[1] = {3'b000, so1};
  assign obs_sum[2] = {3'b000, so2};
  assign obs_sum[3] = so3;
  assign obs_v[0] = sv0;
  assign obs_v[1] = sv1;
  assign obs_v[2] = sv2;
  assign obs_v[3] = sv3;
  assign obs_ovf[0] = ov0;
  assign obs_ovf[1] = ov1;
  assign obs_ovf[2] = ov2;
  assign obs_ovf[3] = ov3;

  task automatic check(input string name, input int inst, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s inst=%0d actual=%0d expected=%0d (cycle %0d)", name, inst, act, exp, cyc);
    end
  endtask

  // Reference: a frame sum is plain integer addition of every operand of every beat, clamped or wrapped.
  task automatic model_beat(input bit first, input bit last);
    for (int i = 0; i < NI; i++) begin
      longint t = 0;
      longint lim = (longint'(1) << AW[i]) - 1;
      exp_t e;
      for (int j = 0; j < NOPS[i]; j++) t += longint'(ops[j] % (32'd1 << OPW[i]));
      m_acc[i] = first ? t : m_acc[i] + t;
      if (m_acc[i] > lim) begin
        m_ovf[i] = 1'b1;
        m_acc[i] = SATV[i] ? lim : m_acc[i] - (lim + 1);
      end
      if (last) begin
        e.inst = i;
        e.sum  = m_acc[i];
        e.ovf  = m_ovf[i];
        e.due  = cyc + DLY[i] + 1;
        sbq.push_back(e);
        m_acc[i] = 0;
      end
    end
  endtask

  task automatic model_clear(input int c);
    for (int i = 0; i < NI; i++) begin
      m_acc[i] = 0;
      m_ovf[i] = 1'b0;
    end
    for (int k = sbq.size() - 1; k >= 0; k--) begin
      if (sbq[k].due > c) sbq.delete(k);
    end
  endtask

  task automatic applyStimulus(input bit v, input bit f, input bit l, input bit c);
    @(posedge clk);
    #1;
    for (int j = 0; j < NB; j++) data_big[j*WB +: WB] = ops[j][WB-1:0];
    for (int j = 0; j < NS; j++) data_small[j*WS +: WS] = ops[j][WS-1:0];
    in_valid = v;
    in_first = f;
    in_last  = l;
    clear    = c;
    if (c) model_clear(cyc);
    else if (v) model_beat(f, l);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic fill(input int unsigned val);
    for (int j = 0; j < NB; j++) ops[j] = val;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last = 1'b0;
    clear = 1'b0;
    sbq.delete();
    for (int i = 0; i < NI; i++) begin
      m_acc[i] = 0;
      m_ovf[i] = 1'b0;
    end
    #2;
    for (int i = 0; i < NI; i++) begin
      check("reset_sum_valid", i, longint'(obs_v[i]), 0);
      check("reset_sum_out", i, longint'(obs_sum[i]), 0);
      check("reset_ovf", i, longint'(obs_ovf[i]), 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: pops the oldest expectation of an instance whenever it presents a sum or is overdue.
  task automatic checkOutput(input int i);
    int idx = -1;
    for (int k = 0; k < sbq.size(); k++) begin
      if (sbq[k].inst == i) begin
        idx = k;
        break;
      end
    end
    if (obs_v[i]) begin
      if (idx < 0) begin
        check("sum_valid_unexpected", i, longint'(obs_v[i]), 0);
      end else begin
        check("sum_out", i, longint'(obs_sum[i]), sbq[idx].sum);
        check("ovf", i, longint'(obs_ovf[i]), longint'(sbq[idx].ovf));
        check("latency_cycle", i, longint'(cyc), longint'(sbq[idx].due));
        sbq.delete(idx);
      end
    end else if (idx >= 0 && sbq[idx].due <= cyc) begin
      check("sum_valid_missing", i, longint'(obs_v[i]), 1);
      sbq.delete(idx);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NI; i++) checkOutput(i);
    end
  end

  initial begin
    bit v, f, l, c;
    reset = 1'b1;
    clear = 1'b0;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last = 1'b0;
    data_big = '0;
    data_small = '0;
    fill(0);
    do_reset();

    $display("[TB] single full-scale beat");
    fill(16383);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    idle(7);

    $display("[TB] three-beat frame of ones");
    fill(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    idle(7);

    $display("[TB] two-beat overflow frame");
    fill(16383);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    idle(7);

    $display("[TB] eight back-to-back single-beat frames");
    for (int n = 0; n < 8; n++) begin
      fill(0);
      ops[0] = n;
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    end
    idle(7);

    $display("[TB] reset and clear mid-frame");
    fill(5);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    idle(8);
    for (int i = 0; i < NI; i++) begin
      check("post_clear_sum_valid", i, longint'(obs_v[i]), 0);
      check("post_clear_sum_out", i, longint'(obs_sum[i]), 0);
      check("post_clear_ovf", i, longint'(obs_ovf[i]), 0);
    end
    fill(2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    idle(7);

    $display("[TB] small tree and mid-frame restart");
    fill(15);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    fill(3);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    idle(7);

    $display("[TB] randomized stream");
    for (int n = 0; n < 400; n++) begin
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 4) == 0);
      l = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 3) == 0) fill(16383);
      else for (int j = 0; j < NB; j++) ops[j] = $urandom_range(0, 16383);
      applyStimulus(v, f, l, c);
    end
    idle(12);

    check("scoreboard_drain", -1, longint'(sbq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
